// File: rtl/hex_page_scheduler_if.sv
// Bus bundle for the 7-segment page scheduler: eight debug source bytes,
// mode controls and the raw pushbutton in; selected page and its two bytes out.
interface hex_page_scheduler_if;
  logic [7:0] in0;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [7:0] in3;
  logic [7:0] in4;
  logic [7:0] in5;
  logic [7:0] in6;
  logic [7:0] in7;
  logic       auto_en;
  logic       next_n;
  logic       hold;
  logic [1:0] page;
  logic [7:0] out0;
  logic [7:0] out1;
  logic       upd;

  // Source side: drives debug bytes and controls, observes the display bytes.
  modport master (
    output in0, in1, in2, in3, in4, in5, in6, in7,
    output auto_en, next_n, hold,
    input  page, out0, out1, upd
  );

  // Scheduler side.
  modport slave (
    input  in0, in1, in2, in3, in4, in5, in6, in7,
    input  auto_en, next_n, hold,
    output page, out0, out1, upd
  );
endinterface

// File: rtl/hex_page_scheduler.sv
// Page scheduler for the 7-segment debug display. Selects one of four
// two-byte pages from eight debug sources, advancing on a dwell timer or a
// debounced active-low pushbutton, with a hold input that freezes everything
// visible. Outputs are registered one cycle behind the page register.
module hex_page_scheduler #(
  parameter int DWELL    = 50_000_000,
  parameter int DEBOUNCE = 1_000_000
) (
  input logic                  clock,
  input logic                  reset,
  hex_page_scheduler_if.slave  bus
);

  localparam int DW_W = (DWELL    > 2) ? $clog2(DWELL)    : 1;
  localparam int DB_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE - 1);

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  logic            s1_q, s2_q;
  logic            db_q, db_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [DW_W-1:0] dw_cnt_q, dw_cnt_d;
  logic [1:0]      page_q, page_d;
  logic [1:0]      shown_q;
  logic [7:0]      out0_q, out1_q;
  logic [7:0]      sel0, sel1;
  logic            upd_q;
  logic            db_flip, press, tick, advance;

  // Two-flop synchronizer; only s2_q is used downstream.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= bus.next_n;
      s2_q <= s1_q;
    end
  end

  // db flips on the edge the mismatch count has reached its last value;
  // only the falling flip (button pressed) is an event.
  assign db_flip = (s2_q != db_q) && (db_cnt_q == DB_LAST);
  assign press   = db_flip && !s2_q;

  // Debounce next-state: count mismatched cycles, clear on match or on flip.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (s2_q != db_q) begin
      if (db_flip) begin
        db_d     = s2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      db_q     <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // A tick and a press in the same cycle collapse into a single advance.
  assign tick    = bus.auto_en && !bus.hold && (dw_cnt_q == DWELL_LAST);
  assign advance = !bus.hold && (tick || press);

  // Dwell next-state: idle at 0 in manual mode, frozen under hold,
  // restarted by a press so a manual advance gets a full dwell period.
  always_comb begin
    dw_cnt_d = dw_cnt_q;
    if (!bus.auto_en)      dw_cnt_d = '0;
    else if (bus.hold)     dw_cnt_d = dw_cnt_q;
    else if (press || tick) dw_cnt_d = '0;
    else                   dw_cnt_d = dw_cnt_q + DW_W'(1);
  end

  // Page state machine next-state: P0 -> P1 -> P2 -> P3 -> P0.
  always_comb begin
    page_d = page_q;
    if (advance) begin
      case (page_q)
        P0:      page_d = P1;
        P1:      page_d = P2;
        P2:      page_d = P3;
        default: page_d = P0;
      endcase
    end
  end

  // Dwell counter and page state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      dw_cnt_q <= '0;
      page_q   <= P0;
    end else begin
      dw_cnt_q <= dw_cnt_d;
      page_q   <= page_d;
    end
  end

  // Source pair selected by the registered page.
  always_comb begin
    sel0 = bus.in0;
    sel1 = bus.in1;
    case (page_q)
      P0:      begin sel0 = bus.in0; sel1 = bus.in1; end
      P1:      begin sel0 = bus.in2; sel1 = bus.in3; end
      P2:      begin sel0 = bus.in4; sel1 = bus.in5; end
      default: begin sel0 = bus.in6; sel1 = bus.in7; end
    endcase
  end

  // Output stage: reload every unheld cycle; upd flags a change of page
  // relative to the page last loaded, not a change of data.
  always_ff @(posedge clock) begin
    if (reset) begin
      out0_q  <= 8'h00;
      out1_q  <= 8'h00;
      shown_q <= P0;
      upd_q   <= 1'b0;
    end else if (!bus.hold) begin
      out0_q  <= sel0;
      out1_q  <= sel1;
      shown_q <= page_q;
      upd_q   <= (page_q != shown_q);
    end else begin
      upd_q   <= 1'b0;
    end
  end

  assign bus.page = page_q;
  assign bus.out0 = out0_q;
  assign bus.out1 = out1_q;
  assign bus.upd  = upd_q;

endmodule

// File: tb/tb_hex_page_scheduler.sv
// Directed bench for hex_page_scheduler with DWELL=8, DEBOUNCE=4 and
// sources 0x10..0x17. Inputs change and outputs are sampled 1 ns after
// each rising edge; "edge N" below is the edge just completed.
module tb_hex_page_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  hex_page_scheduler_if dut_if ();

  hex_page_scheduler #(.DWELL(8), .DEBOUNCE(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (dut_if)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ae);
    rst = 1'b1;
    dut_if.in0 = 8'h10; dut_if.in1 = 8'h11; dut_if.in2 = 8'h12; dut_if.in3 = 8'h13;
    dut_if.in4 = 8'h14; dut_if.in5 = 8'h15; dut_if.in6 = 8'h16; dut_if.in7 = 8'h17;
    dut_if.auto_en = ae;
    dut_if.next_n  = 1'b1;
    dut_if.hold    = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Stimulus only: hold the button low nlow cycles, then high 8 cycles.
  task automatic press_release(input int nlow);
    dut_if.next_n = 1'b0;
    for (int i = 0; i < nlow; i++) step();
    dut_if.next_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_reset_auto();
    logic [1:0] ep;
    logic [7:0] e0;
    do_reset(1'b1);
    nvec++;
    if (dut_if.page !== 2'd0 || dut_if.out0 !== 8'h00 || dut_if.out1 !== 8'h00 || dut_if.upd !== 1'b0) begin
      $display("FAIL reset_state: page=%0d out0=%h out1=%h upd=%b, want 0/00/00/0",
               dut_if.page, dut_if.out0, dut_if.out1, dut_if.upd);
      nerr++;
    end
    for (int e = 1; e <= 33; e++) begin
      step();
      ep = 2'((e / 8) % 4);
      e0 = 8'h10 + 8'(2 * (((e - 1) / 8) % 4));
      nvec++;
      if (dut_if.page !== ep || dut_if.out0 !== e0 || dut_if.out1 !== e0 + 8'h01 ||
          dut_if.upd !== (e >= 9 && (e % 8) == 1)) begin
        $display("FAIL auto_edge%0d: page=%0d out0=%h out1=%h upd=%b, want %0d/%h/%h/%b",
                 e, dut_if.page, dut_if.out0, dut_if.out1, dut_if.upd,
                 ep, e0, e0 + 8'h01, (e >= 9 && (e % 8) == 1));
        nerr++;
      end
    end
  endtask

  task automatic test_manual_press();
    logic [1:0] ep;
    do_reset(1'b0);
    step();
    dut_if.next_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      ep = (i >= 5) ? 2'd1 : 2'd0;
      nvec++;
      if (dut_if.page !== ep || dut_if.upd !== (i == 6)) begin
        $display("FAIL press_edge%0d: page=%0d upd=%b, want %0d/%b", i, dut_if.page, dut_if.upd, ep, (i == 6));
        nerr++;
      end
    end
    nvec++;
    if (dut_if.out0 !== 8'h12 || dut_if.out1 !== 8'h13) begin
      $display("FAIL press_outputs: out0=%h out1=%h, want 12/13", dut_if.out0, dut_if.out1);
      nerr++;
    end
    dut_if.next_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    for (int k = 2; k <= 4; k++) begin
      press_release(8);
      nvec++;
      if (dut_if.page !== 2'(k % 4)) begin
        $display("FAIL press_count%0d: page=%0d, want %0d", k, dut_if.page, k % 4);
        nerr++;
      end
    end
  endtask

  task automatic test_bounce();
    logic [15:0] pat;
    logic        seen;
    pat  = 16'b1111_1111_1010_1000;
    seen = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) begin
      dut_if.next_n = pat[i];
      step();
      if (dut_if.upd === 1'b1 || dut_if.page !== 2'd0) seen = 1'b1;
    end
    for (int i = 0; i < 6; i++) step();
    nvec++;
    if (seen !== 1'b0 || dut_if.page !== 2'd0) begin
      $display("FAIL bounce: disturbed=%b page=%0d, want 0/0", seen, dut_if.page);
      nerr++;
    end
  endtask

  task automatic test_press_clears_dwell();
    do_reset(1'b1);
    step();
    dut_if.next_n = 1'b0;
    for (int e = 2; e <= 15; e++) begin
      step();
      if (e == 7 || e == 8 || e == 14 || e == 15) begin
        nvec++;
        if (dut_if.page !== ((e == 15) ? 2'd2 : 2'd1)) begin
          $display("FAIL press_clear_edge%0d: page=%0d, want %0d", e, dut_if.page, (e == 15) ? 2 : 1);
          nerr++;
        end
      end
    end
    dut_if.next_n = 1'b1;
  endtask

  task automatic test_simultaneous();
    logic [1:0] ep;
    do_reset(1'b1);
    step();
    step();
    dut_if.next_n = 1'b0;
    for (int e = 3; e <= 16; e++) begin
      step();
      if (e == 7 || e == 8 || e == 9 || e == 15 || e == 16) begin
        ep = (e == 7) ? 2'd0 : (e == 16) ? 2'd2 : 2'd1;
        nvec++;
        if (dut_if.page !== ep) begin
          $display("FAIL simul_edge%0d: page=%0d, want %0d", e, dut_if.page, ep);
          nerr++;
        end
      end
    end
    dut_if.next_n = 1'b1;
  endtask

  task automatic test_hold();
    logic bad;
    do_reset(1'b0);
    press_release(8);
    press_release(8);
    nvec++;
    if (dut_if.page !== 2'd2 || dut_if.out0 !== 8'h14) begin
      $display("FAIL hold_setup: page=%0d out0=%h, want 2/14", dut_if.page, dut_if.out0);
      nerr++;
    end
    dut_if.hold = 1'b1;
    dut_if.in4  = 8'hAA;
    bad = 1'b0;
    dut_if.next_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dut_if.page !== 2'd2 || dut_if.out0 !== 8'h14 || dut_if.upd !== 1'b0) bad = 1'b1;
    end
    dut_if.next_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (dut_if.page !== 2'd2 || dut_if.out0 !== 8'h14 || dut_if.upd !== 1'b0) bad = 1'b1;
    end
    nvec++;
    if (bad !== 1'b0) begin
      $display("FAIL hold_freeze: page=%0d out0=%h upd=%b, want 2/14/0 throughout",
               dut_if.page, dut_if.out0, dut_if.upd);
      nerr++;
    end
    dut_if.hold = 1'b0;
    step();
    nvec++;
    if (dut_if.out0 !== 8'hAA || dut_if.upd !== 1'b0 || dut_if.page !== 2'd2) begin
      $display("FAIL hold_release: out0=%h upd=%b page=%0d, want AA/0/2", dut_if.out0, dut_if.upd, dut_if.page);
      nerr++;
    end
    for (int i = 0; i < 10; i++) step();
    nvec++;
    if (dut_if.page !== 2'd2) begin
      $display("FAIL hold_dropped_press: page=%0d, want 2", dut_if.page);
      nerr++;
    end
  endtask

  task automatic test_hold_dwell();
    logic bad;
    do_reset(1'b1);
    step(); step(); step();
    dut_if.hold = 1'b1;
    bad = 1'b0;
    for (int e = 4; e <= 23; e++) begin
      step();
      if (dut_if.page !== 2'd0) bad = 1'b1;
    end
    dut_if.hold = 1'b0;
    for (int e = 24; e <= 28; e++) begin
      step();
      if (e == 27 || e == 28) begin
        nvec++;
        if (bad !== 1'b0 || dut_if.page !== ((e == 28) ? 2'd1 : 2'd0)) begin
          $display("FAIL hold_dwell_edge%0d: page=%0d moved_in_hold=%b, want %0d/0",
                   e, dut_if.page, bad, (e == 28) ? 1 : 0);
          nerr++;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic bad;
    // Interrupted debounce, button released during reset.
    do_reset(1'b0);
    dut_if.next_n = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    dut_if.next_n = 1'b1;
    step(); step();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (dut_if.page !== 2'd0 || dut_if.upd !== 1'b0) bad = 1'b1;
    end
    nvec++;
    if (bad !== 1'b0) begin
      $display("FAIL reset_mid_debounce: page=%0d upd=%b, want 0/0", dut_if.page, dut_if.upd);
      nerr++;
    end
    // Button kept low through reset: the count restarts from zero.
    dut_if.next_n = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i >= 4) begin
        nvec++;
        if (dut_if.page !== ((i == 5) ? 2'd1 : 2'd0)) begin
          $display("FAIL reset_count_discard_edge%0d: page=%0d, want %0d", i, dut_if.page, (i == 5) ? 1 : 0);
          nerr++;
        end
      end
    end
    dut_if.next_n = 1'b1;
    // Reset in the middle of a dwell period, while on page 1.
    do_reset(1'b1);
    for (int i = 0; i < 12; i++) step();
    rst = 1'b1;
    step(); step();
    nvec++;
    if (dut_if.page !== 2'd0 || dut_if.out0 !== 8'h00 || dut_if.out1 !== 8'h00 || dut_if.upd !== 1'b0) begin
      $display("FAIL reset_mid_dwell: page=%0d out0=%h out1=%h upd=%b, want 0/00/00/0",
               dut_if.page, dut_if.out0, dut_if.out1, dut_if.upd);
      nerr++;
    end
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e >= 7) begin
        nvec++;
        if (dut_if.page !== ((e == 8) ? 2'd1 : 2'd0)) begin
          $display("FAIL reset_dwell_restart_edge%0d: page=%0d, want %0d", e, dut_if.page, (e == 8) ? 1 : 0);
          nerr++;
        end
      end
    end
  endtask

  initial begin
    test_reset_auto();
    test_manual_press();
    test_bounce();
    test_press_clears_dwell();
    test_simultaneous();
    test_hold();
    test_hold_dwell();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/hex_page_scheduler.md
# hex_page_scheduler

Page scheduler for the board's 7-segment debug display. Eight 8-bit debug sources (PC, IR, register taps) are exposed as four pages of two bytes each. The block picks the visible page and presents two registered bytes to the downstream per-nibble HEX decoders. Pages advance on a dwell timer (auto mode) or on a debounced pushbutton, and a hold input freezes the display for inspection.

## Interface
- DWELL, 50_000_000: clock cycles each page is shown in auto mode; must be ≥2.
- DEBOUNCE, 1_000_000: consecutive stable cycles required to accept a pushbutton level change; must be ≥2.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in0 .. in7  in  8 each  debug source bytes; page p shows in(2p) and in(2p+1).
- auto_en  in  1  1 = dwell timer advances pages; 0 = manual only.
- next_n  in  1  raw active-low pushbutton, asynchronous to clock.
- hold  in  1  1 = freeze page, outputs and dwell count; button events are discarded.
- page  out  2  current page, 0..3.
- out0  out  8  registered in(2·page).
- out1  out  8  registered in(2·page+1).
- upd  out  1  one-cycle pulse in the first cycle out0/out1 show a new page.

## Operation
- Sync: next_n passes through two flops, s1 then s2, both reset to 1. Nothing downstream ever sees raw next_n.
- Debounce:
  - Debounced level db resets to 1. A counter resets to 0.
  - While s2 == db, the counter is held at 0.
  - While s2 != db, the counter increments each cycle.
  - When the counter reaches DEBOUNCE-1 while still mismatched, db takes s2 and the counter clears.
  - A db transition 1→0 is a press event. A 0→1 transition is ignored.
- Dwell counter:
  - Counts 0..DWELL-1 while auto_en=1 and hold=0.
  - Reaching DWELL-1 generates a tick and wraps to 0.
  - Forced to 0 when auto_en=0.
  - Holds its value while hold=1.
- Page state machine, states P0→P1→P2→P3→P0:
  - Advance by exactly one on (tick OR press) with hold=0. A tick and a press in the same cycle still advance only one page.
  - A press also clears the dwell counter.
  - A press while hold=1 is dropped, not queued.
- Output stage:
  - Each cycle with hold=0, out0/out1 load the source pair selected by the registered page.
  - With hold=1, out0/out1 keep their values.
  - upd is set on the edge where out0/out1 load a page different from the one they last loaded. Otherwise it is cleared.
- Reset values: page=0, out0=0x00, out1=0x00, upd=0, db=1, s1=s2=1, both counters 0. Reset overrides all other inputs, including mid-debounce or mid-dwell; a partial debounce count is discarded.

## Timing
- Outputs follow page by exactly one cycle; upd is coincident with the first cycle of new output data.
- Button latency, counting the first edge that samples next_n=0 as edge 0, with next_n held low:
  - db falls and page increments at edge DEBOUNCE+1.
  - out0/out1 show the new page and upd=1 after edge DEBOUNCE+2.
- A low pulse on next_n shorter than DEBOUNCE cycles (as seen at s2) produces no event.
- Auto latency: after reset releases with auto_en=1, page increments at edge DWELL after the first post-reset edge, and every DWELL edges thereafter.
- First post-reset edge: out0=in0, out1=in1, upd=0, because page did not change.
- Source bytes are sampled every cycle with hold=0. Changing input values do not pulse upd.
- Releasing hold: loading resumes on the next edge and the dwell counter resumes from its held value.

## Test plan
Use DWELL=8 and DEBOUNCE=4 throughout; in0..in7 = 0x10..0x17.
- Reset/auto: reset 2 cycles, auto_en=1 → page=0, out0=0x10, out1=0x11.
  - Page becomes 1 at edge 8, with out0=0x12, out1=0x13 and a single upd one edge later.
  - Sequence 1,2,3,0 every 8 edges; wraps 3→0 at edge 32.
- Manual press: auto_en=0, next_n low for 10 cycles → exactly one advance, 0→1, at edge 5 counted from edge 0 = first sample low.
  - A second press after release advances to 2.
  - 4 presses total wrap back to 0.
- Bounce: auto_en=0, next_n low 3 cycles then high (and a 1-0-1-0 toggle train) → page stays 0, upd never asserts.
- Simultaneous: auto_en=1 with the press event timed to the same edge as the dwell tick → page advances by one only, and the dwell counter restarts at 0.
- Hold: hold=1 in page 2, then change in4 to 0xAA and press → page stays 2, out0 stays 0x14, no upd, dwell frozen.
  - On hold=0, out0=0xAA next edge; the dropped press never takes effect.
- Reset mid-operation: assert reset 2 edges into a debounce, and again mid-dwell → all outputs return to reset values, and no page advance occurs from the interrupted press.
